// File: rtl/truth_table_scanner_if.sv
// Handshake bundle between the truth-table scanner and its driver/checker.
// Optional mismatch outputs exist only when TT_SCAN_MISMATCH_EN is defined.
interface truth_table_scanner_if #(
    parameter int N_INPUTS = 3
);
    localparam int TW = 2 ** N_INPUTS;

    logic                start;
    logic                dut_out;
    logic [N_INPUTS-1:0] vars_out;
    logic                busy;
    logic                done;
    logic [TW-1:0]       table_out;
    logic                pass;

`ifdef TT_SCAN_MISMATCH_EN
    logic [N_INPUTS:0]   err_cnt;
    logic [N_INPUTS-1:0] first_fail;
    logic                any_fail;

    modport master (
        output start,
        output dut_out,
        input  vars_out,
        input  busy,
        input  done,
        input  table_out,
        input  pass,
        input  err_cnt,
        input  first_fail,
        input  any_fail
    );

    modport slave (
        input  start,
        input  dut_out,
        output vars_out,
        output busy,
        output done,
        output table_out,
        output pass,
        output err_cnt,
        output first_fail,
        output any_fail
    );
`else
    modport master (
        output start,
        output dut_out,
        input  vars_out,
        input  busy,
        input  done,
        input  table_out,
        input  pass
    );

    modport slave (
        input  start,
        input  dut_out,
        output vars_out,
        output busy,
        output done,
        output table_out,
        output pass
    );
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/capture stage: walks all input vectors of a combinational
// block, records its truth table and compares it with EXPECTED.
// Optional feature macro: TT_SCAN_MISMATCH_EN (error count / first failing index).
module truth_table_scanner #(
    parameter int                      N_INPUTS      = 3,
    parameter int                      SETTLE_CYCLES = 1,
    parameter logic [2**N_INPUTS-1:0]  EXPECTED      = 8'b1010_1100
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_scanner_if.slave  bus
);
    localparam int TW = 2 ** N_INPUTS;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS:0] IDX_MAX = (N_INPUTS + 1)'(TW - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [N_INPUTS:0]   idx;
    logic [CW-1:0]       cnt;
    logic                busy_q;
    logic                done_q;
    logic [TW-1:0]       table_q;
    logic                pass_q;

    logic                accept;
    logic                sample;
    logic                last;
    logic                settle_end;

`ifdef TT_SCAN_MISMATCH_EN
    logic [N_INPUTS:0]   err_q;
    logic [N_INPUTS-1:0] first_q;
    logic                any_q;
    logic                miss;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        sample     = 1'b0;
        last       = (idx == IDX_MAX);
        settle_end = (cnt == CNT_MAX);
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample  = 1'b1;
                state_d = last ? FINISH : SETTLE;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TT_SCAN_MISMATCH_EN
    // A sampled bit disagreeing with the expected mask (X/Z never counts)
    always_comb begin
        miss = 1'b0;
        if (bus.dut_out != EXPECTED[idx[N_INPUTS-1:0]]) begin
            miss = 1'b1;
        end
    end
`endif

    // Datapath: vector index, settle counter, captured table and verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            pass_q  <= 1'b0;
`ifdef TT_SCAN_MISMATCH_EN
            err_q   <= '0;
            first_q <= '0;
            any_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                idx     <= '0;
                cnt     <= '0;
                table_q <= '0;
                pass_q  <= 1'b0;
                busy_q  <= 1'b1;
`ifdef TT_SCAN_MISMATCH_EN
                err_q   <= '0;
                first_q <= '0;
                any_q   <= 1'b0;
`endif
            end
            if (state == SETTLE && !settle_end) begin
                cnt <= cnt + CW'(1);
            end
            if (sample) begin
                table_q[idx[N_INPUTS-1:0]] <= bus.dut_out;
                if (!last) begin
                    idx <= idx + (N_INPUTS + 1)'(1);
                    cnt <= '0;
                end
`ifdef TT_SCAN_MISMATCH_EN
                if (miss) begin
                    err_q <= err_q + (N_INPUTS + 1)'(1);
                    any_q <= 1'b1;
                    if (err_q == '0) begin
                        first_q <= idx[N_INPUTS-1:0];
                    end
                end
`endif
            end
            if (state == FINISH) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                pass_q <= (table_q == EXPECTED);
            end
        end
    end

    assign bus.vars_out  = idx[N_INPUTS-1:0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;
`ifdef TT_SCAN_MISMATCH_EN
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = first_q;
    assign bus.any_fail   = any_q;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: two instances (settle 1 and 3)
// scan random and named functions; a monitor checks every done pulse.
module tb_truth_table_scanner;
    localparam int TW = 8;

    typedef struct {
        logic [7:0] tbl;
        logic       pas;
        int         acc;
        int         done_at;
        int         err;
        int         ff;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [7:0] f0 = 8'h00;
    logic [7:0] f1 = 8'h00;
    exp_t q0[$];
    exp_t q1[$];

    truth_table_scanner_if #(.N_INPUTS(3)) b0 ();
    truth_table_scanner_if #(.N_INPUTS(3)) b1 ();

    truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(3)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign b0.dut_out = f0[b0.vars_out];
    assign b1.dut_out = f1[b1.vars_out];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: the scanned function is given as minterm set m; the target is Sm(2,3,5,7).
    function automatic exp_t model(input logic [7:0] m, input int acc, input int s);
        exp_t e;
        logic want;
        e.tbl = 8'h00;
        e.err = 0;
        e.ff  = 0;
        for (int k = 0; k < TW; k++) begin
            e.tbl[k] = m[k];
            want = (k == 2 || k == 3 || k == 5 || k == 7);
            if (m[k] != want) begin
                if (e.err == 0) e.ff = k;
                e.err++;
            end
        end
        e.pas     = (e.err == 0);
        e.acc     = acc;
        e.done_at = acc + TW * (s + 1) + 1;
        return e;
    endfunction

    function automatic int exp_vars(input int d, input int s);
        int v;
        v = d / (s + 1);
        return (v > TW - 1) ? TW - 1 : v;
    endfunction

    // Monitor: scan-progress checks while a scan is outstanding, verdict at done
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (!reset) begin
            if (b0.done) begin
                if (q0.size() == 0) begin
                    check("u0 unexpected done", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("u0 table", 32'(b0.table_out), 32'(e.tbl));
                    check("u0 pass", 32'(b0.pass), 32'(e.pas));
                    check("u0 done cycle", cyc, e.done_at);
                    check("u0 busy at done", 32'(b0.busy), 32'd0);
`ifdef TT_SCAN_MISMATCH_EN
                    check("u0 err_cnt", 32'(b0.err_cnt), e.err);
                    check("u0 first_fail", 32'(b0.first_fail), e.ff);
                    check("u0 any_fail", 32'(b0.any_fail), 32'(e.err != 0));
`endif
                end
            end else if (q0.size() != 0) begin
                d = cyc - q0[0].acc;
                if (d >= 0 && d <= TW * 2) begin
                    check("u0 vars_out", 32'(b0.vars_out), exp_vars(d, 1));
                    check("u0 busy", 32'(b0.busy), 32'd1);
                end
            end
            if (b1.done) begin
                if (q1.size() == 0) begin
                    check("u1 unexpected done", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("u1 table", 32'(b1.table_out), 32'(e.tbl));
                    check("u1 pass", 32'(b1.pass), 32'(e.pas));
                    check("u1 done cycle", cyc, e.done_at);
                    check("u1 busy at done", 32'(b1.busy), 32'd0);
`ifdef TT_SCAN_MISMATCH_EN
                    check("u1 err_cnt", 32'(b1.err_cnt), e.err);
                    check("u1 first_fail", 32'(b1.first_fail), e.ff);
                    check("u1 any_fail", 32'(b1.any_fail), 32'(e.err != 0));
`endif
                end
            end else if (q1.size() != 0) begin
                d = cyc - q1[0].acc;
                if (d >= 0 && d <= TW * 4) begin
                    check("u1 vars_out", 32'(b1.vars_out), exp_vars(d, 3));
                    check("u1 busy", 32'(b1.busy), 32'd1);
                end
            end
        end
    end

    task automatic scan(input int u, input logic [7:0] m);
        @(negedge clk);
        if (u == 0) begin
            f0 = m;
            b0.start = 1'b1;
        end else begin
            f1 = m;
            b1.start = 1'b1;
        end
        @(posedge clk);
        #1;
        if (u == 0) q0.push_back(model(m, cyc, 1));
        else q1.push_back(model(m, cyc, 3));
        b0.start = 1'b0;
        b1.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            check("done timeout", 32'd1, 32'd0);
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " u0 vars"}, 32'(b0.vars_out), 32'd0);
        check({tag, " u0 busy"}, 32'(b0.busy), 32'd0);
        check({tag, " u0 done"}, 32'(b0.done), 32'd0);
        check({tag, " u0 table"}, 32'(b0.table_out), 32'd0);
        check({tag, " u0 pass"}, 32'(b0.pass), 32'd0);
        check({tag, " u1 busy"}, 32'(b1.busy), 32'd0);
        check({tag, " u1 table"}, 32'(b1.table_out), 32'd0);
`ifdef TT_SCAN_MISMATCH_EN
        check({tag, " u0 err_cnt"}, 32'(b0.err_cnt), 32'd0);
        check({tag, " u0 first_fail"}, 32'(b0.first_fail), 32'd0);
        check({tag, " u0 any_fail"}, 32'(b0.any_fail), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] m;
        int n;
        reset = 1'b1;
        b0.start = 1'b0;
        b1.start = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Named functions
        scan(0, 8'hAC);
        drain();
        scan(0, 8'h00);
        drain();
        scan(1, 8'h96);
        drain();
        scan(1, 8'hAC);
        drain();

        // Async reset in the middle of a scan
        @(negedge clk);
        f0 = 8'hAC;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        n = 0;
        while (b0.vars_out != 3'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach vector 4", 32'(b0.vars_out), 32'd4);
        #2 reset = 1'b1;
        #1 check_zero("mid-scan reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        scan(0, 8'hAC);
        drain();

        // Start pulsed while busy is ignored
        scan(0, 8'h5A);
        repeat (4) @(negedge clk);
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        drain();

        // Start held high: back-to-back scans, table cleared on second accept
        @(negedge clk);
        f0 = 8'hAC;
        b0.start = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(model(8'hAC, cyc, 1));
        q0.push_back(model(8'hAC, cyc + 18, 1));
        for (int i = 1; i <= 35; i++) begin
            @(posedge clk);
            if (i == 18) begin
                #1;
                check("held start table cleared", 32'(b0.table_out), 32'd0);
                check("held start pass cleared", 32'(b0.pass), 32'd0);
            end
        end
        #1 b0.start = 1'b0;
        drain();

        // Random functions on both instances
        for (int i = 0; i < 10; i++) begin
            m = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m = 8'hAC;
            scan(int'($urandom_range(0, 1)), m);
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
